alu_multicycle: RTL



---
 rtl/alu_multicycle.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: one request at a time, shifts iterate SHIFT_STEP bits per cycle.
// The first shift step happens at accept, so shift latency is ceil(amount/SHIFT_STEP).
module alu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Sel,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int AW = $clog2(WIDTH);
  localparam logic [AW-1:0] STEP = AW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AW-1:0]    rem_q, rem_d;

  logic [AW-1:0]    amt, first_step, next_step;
  logic [WIDTH-1:0] first_val, next_val;
  logic             is_shift;

  function automatic logic [WIDTH-1:0] shift_by(input logic [3:0] op,
                                                input logic [WIDTH-1:0] val,
                                                input logic [AW-1:0] n);
    case (op)
      4'b0101: shift_by = val << n;
      4'b0110: shift_by = val >> n;
      default: shift_by = WIDTH'($signed(val) >>> n);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] alu_value(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      4'b0000: alu_value = a + b;
      4'b0001: alu_value = a - b;
      4'b0010: alu_value = a & b;
      4'b0011: alu_value = a | b;
      4'b0100: alu_value = a ^ b;
      4'b1000: alu_value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_value = '0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;

    amt        = operand_1[AW-1:0];
    is_shift   = (ALU_Sel == 4'b0101) || (ALU_Sel == 4'b0110) || (ALU_Sel == 4'b0111);
    first_step = (amt < STEP) ? amt : STEP;
    first_val  = shift_by(ALU_Sel, operand_0, first_step);
    next_step  = (rem_q < STEP) ? rem_q : STEP;
    next_val   = shift_by(op_q, work_q, next_step);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = ALU_Sel;
          if (is_shift) begin
            rem_d = amt - first_step;
            if (amt == first_step) begin
              state_d  = DONE;
              result_d = first_val;
            end else begin
              state_d = SHIFT;
              work_d  = first_val;
            end
          end else begin
            state_d  = DONE;
            result_d = alu_value(ALU_Sel, operand_0, operand_1);
          end
        end
      end
      SHIFT: begin
        rem_d  = rem_q - next_step;
        work_d = next_val;
        if (rem_q == next_step) begin
          state_d  = DONE;
          result_d = next_val;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
endmodule
